// File: rtl/lsu_byte_splitter.sv
// Load/store initiator for data_memory. Aligned accesses take one memory cycle.
// Misaligned halfword/word accesses are split into byte accesses and reassembled.
module lsu_byte_splitter #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_MemW,
  output logic        mem_memRead,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t      state;
  logic        write_r;
  logic [2:0]  funct3_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        mis_r;
  logic [1:0]  last_r;
  logic [1:0]  k_r;
  logic [31:0] asm_r;

  logic        req_mis_s;
  logic [1:0]  req_last_s;
  logic        req_legal_s;
  logic        req_err_s;
  logic        src_write_s;
  logic [2:0]  src_f3_s;
  logic [31:0] src_addr_s;
  logic [31:0] src_wdata_s;
  logic        src_mis_s;
  logic [1:0]  src_k_s;
  logic [31:0] cmd_addr_s;
  logic [31:0] cmd_wdata_s;
  logic [2:0]  cmd_f3_s;
  logic [31:0] asm_s;
  logic [31:0] load_val_s;

  // Classify the incoming request: legality, misalignment and last byte index.
  always_comb begin
    req_mis_s  = 1'b0;
    req_last_s = 2'd0;
    if ((req_funct3[1:0] == 2'b01) && req_addr[0]) begin
      req_mis_s  = 1'b1;
      req_last_s = 2'd1;
    end else if ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00)) begin
      req_mis_s  = 1'b1;
      req_last_s = 2'd3;
    end else begin
      req_mis_s  = 1'b0;
      req_last_s = 2'd0;
    end
    if (req_write) begin
      req_legal_s = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010);
    end else begin
      req_legal_s = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                    (req_funct3 == 3'b101);
    end
    req_err_s = !req_legal_s || (req_mis_s && !ALLOW_MISALIGNED);
  end

  // Memory command for the next access cycle: first byte from the request, later ones from the captured copy.
  always_comb begin
    if (state == IDLE) begin
      src_write_s = req_write;
      src_f3_s    = req_funct3;
      src_addr_s  = req_addr;
      src_wdata_s = req_wdata;
      src_mis_s   = req_mis_s;
      src_k_s     = 2'd0;
    end else begin
      src_write_s = write_r;
      src_f3_s    = funct3_r;
      src_addr_s  = addr_r;
      src_wdata_s = wdata_r;
      src_mis_s   = mis_r;
      src_k_s     = k_r + 2'd1;
    end
    if (src_mis_s) begin
      cmd_addr_s  = src_addr_s + {30'd0, src_k_s};
      cmd_f3_s    = src_write_s ? 3'b000 : 3'b100;
      cmd_wdata_s = {24'd0, src_wdata_s[{src_k_s, 3'b000} +: 8]};
    end else begin
      cmd_addr_s  = src_addr_s;
      cmd_f3_s    = src_f3_s;
      cmd_wdata_s = src_wdata_s;
    end
  end

  // Merge the current byte into the assembly word and extend the final load result.
  always_comb begin
    asm_s = asm_r;
    asm_s[{k_r, 3'b000} +: 8] = mem_read_data[7:0];
    if (!mis_r) begin
      load_val_s = mem_read_data;
    end else begin
      case (funct3_r)
        3'b001:  load_val_s = {{16{asm_s[15]}}, asm_s[15:0]};
        3'b101:  load_val_s = {16'd0, asm_s[15:0]};
        default: load_val_s = asm_s;
      endcase
    end
  end

  // Control FSM with registered handshake and memory-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= 32'd0;
      mem_address    <= 32'd0;
      mem_write_data <= 32'd0;
      mem_funct3     <= 3'd0;
      mem_MemW       <= 1'b0;
      mem_memRead    <= 1'b0;
      write_r        <= 1'b0;
      funct3_r       <= 3'd0;
      addr_r         <= 32'd0;
      wdata_r        <= 32'd0;
      mis_r          <= 1'b0;
      last_r         <= 2'd0;
      k_r            <= 2'd0;
      asm_r          <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          if (req_valid && req_ready) begin
            write_r   <= req_write;
            funct3_r  <= req_funct3;
            addr_r    <= req_addr;
            wdata_r   <= req_wdata;
            mis_r     <= req_mis_s;
            last_r    <= req_last_s;
            k_r       <= 2'd0;
            asm_r     <= 32'd0;
            req_ready <= 1'b0;
            if (req_err_s) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              state          <= ACCESS;
              mem_address    <= cmd_addr_s;
              mem_write_data <= cmd_wdata_s;
              mem_funct3     <= cmd_f3_s;
              mem_MemW       <= req_write;
              mem_memRead    <= !req_write;
            end
          end
        end
        ACCESS: begin
          asm_r <= asm_s;
          if (k_r == last_r) begin
            state       <= RESP;
            resp_valid  <= 1'b1;
            resp_err    <= 1'b0;
            resp_rdata  <= write_r ? 32'd0 : load_val_s;
            mem_MemW    <= 1'b0;
            mem_memRead <= 1'b0;
          end else begin
            k_r            <= k_r + 2'd1;
            mem_address    <= cmd_addr_s;
            mem_write_data <= cmd_wdata_s;
            mem_funct3     <= cmd_f3_s;
          end
        end
        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          req_ready   <= 1'b1;
          resp_valid  <= 1'b0;
          resp_err    <= 1'b0;
          mem_MemW    <= 1'b0;
          mem_memRead <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_byte_splitter.sv
// Directed bench for lsu_byte_splitter with a behavioural data_memory model,
// a vector table for single requests and hand sequences for reset and no-split mode.
module tb_lsu_byte_splitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, nm_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;
  logic        mem_MemW, mem_memRead;
  logic [2:0]  mem_funct3;
  logic        nm_ready, nm_resp_valid, nm_err, nm_MemW, nm_memRead;
  logic [31:0] nm_rdata, nm_addr, nm_wdata;
  logic [2:0]  nm_f3;

  int checks = 0, errors = 0, both_hi = 0;
  logic        init_mem = 1'b0;
  logic [7:0]  mem [0:1023];
  logic [31:0] log_addr [0:15];
  logic [7:0]  log_data [0:15];
  logic [2:0]  log_f3 [0:15];
  int          log_n = 0;

  always #5 clk = ~clk;

  lsu_byte_splitter #(.ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_MemW(mem_MemW), .mem_memRead(mem_memRead), .mem_funct3(mem_funct3),
    .mem_read_data(mem_read_data));

  lsu_byte_splitter #(.ALLOW_MISALIGNED(1'b0)) u_nomis (
    .clk(clk), .rst_n(rst_n), .req_valid(nm_valid), .req_ready(nm_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(nm_resp_valid), .resp_rdata(nm_rdata),
    .resp_err(nm_err), .mem_address(nm_addr), .mem_write_data(nm_wdata),
    .mem_MemW(nm_MemW), .mem_memRead(nm_memRead), .mem_funct3(nm_f3),
    .mem_read_data(32'd0));

  // data_memory model: combinational little-endian read, write on the rising edge.
  logic [9:0] ra;
  logic [7:0] b0, b1, b2, b3;
  assign ra = mem_address[9:0];
  assign b0 = mem[ra];
  assign b1 = mem[ra + 10'd1];
  assign b2 = mem[ra + 10'd2];
  assign b3 = mem[ra + 10'd3];
  always_comb begin
    case (mem_funct3)
      3'b000:  mem_read_data = {{24{b0[7]}}, b0};
      3'b001:  mem_read_data = {{16{b1[7]}}, b1, b0};
      3'b010:  mem_read_data = {b3, b2, b1, b0};
      3'b100:  mem_read_data = {24'd0, b0};
      3'b101:  mem_read_data = {16'd0, b1, b0};
      default: mem_read_data = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      {mem[10'h103], mem[10'h102], mem[10'h101], mem[10'h100]} <= 32'h44332211;
      {mem[10'h107], mem[10'h106], mem[10'h105], mem[10'h104]} <= 32'h88776655;
      {mem[10'h10B], mem[10'h10A], mem[10'h109], mem[10'h108]} <= 32'h000000F0;
      log_n <= 0;
    end else if (mem_MemW) begin
      if (log_n < 16) begin
        log_addr[log_n] <= mem_address;
        log_data[log_n] <= mem_write_data[7:0];
        log_f3[log_n]   <= mem_funct3;
        log_n <= log_n + 1;
      end
      mem[ra] <= mem_write_data[7:0];
      if (mem_funct3 != 3'b000) mem[ra + 10'd1] <= mem_write_data[15:8];
      if (mem_funct3 == 3'b010) begin
        mem[ra + 10'd2] <= mem_write_data[23:16];
        mem[ra + 10'd3] <= mem_write_data[31:24];
      end
    end
  end

  always @(negedge clk) begin
    if (mem_MemW && mem_memRead) both_hi <= both_hi + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic pulse_init();
    @(negedge clk); init_mem = 1'b1;
    @(negedge clk); init_mem = 1'b0;
  endtask

  task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rdata,
                         output logic err, output int lat, output int acc);
    int n;
    @(negedge clk);
    req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'hDEAD_BEEF; req_wdata = 32'h0BAD_F00D;
    lat = 1; acc = 0;
    while (!resp_valid && lat < 20) begin
      if (mem_MemW || mem_memRead) acc++;
      @(negedge clk);
      lat++;
    end
    rdata = resp_rdata; err = resp_err;
    if (!resp_valid) lat = -1;
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_acc;
  } vec_t;

  vec_t vecs [12];
  logic [7:0] exp_b [4];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, acc, bad;

    vecs[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h44332211, 1'b0, 2, 1};
    vecs[1]  = '{1'b0, 3'b010, 32'h102, 32'h0,        32'h66554433, 1'b0, 5, 4};
    vecs[2]  = '{1'b0, 3'b001, 32'h107, 32'h0,        32'hFFFFF088, 1'b0, 3, 2};
    vecs[3]  = '{1'b0, 3'b101, 32'h107, 32'h0,        32'h0000F088, 1'b0, 3, 2};
    vecs[4]  = '{1'b0, 3'b000, 32'h107, 32'h0,        32'hFFFFFF88, 1'b0, 2, 1};
    vecs[5]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h00000044, 1'b0, 2, 1};
    vecs[6]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h00004433, 1'b0, 2, 1};
    vecs[7]  = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h00000000, 1'b1, 1, 0};
    vecs[8]  = '{1'b1, 3'b100, 32'h100, 32'h12345678, 32'h00000000, 1'b1, 1, 0};
    vecs[9]  = '{1'b1, 3'b010, 32'h101, 32'hAABBCCDD, 32'h00000000, 1'b0, 5, 4};
    vecs[10] = '{1'b0, 3'b010, 32'h100, 32'h0,        32'hBBCCDD11, 1'b0, 2, 1};
    vecs[11] = '{1'b0, 3'b010, 32'h104, 32'h0,        32'h887766AA, 1'b0, 2, 1};
    exp_b[0] = 8'hDD; exp_b[1] = 8'hCC; exp_b[2] = 8'hBB; exp_b[3] = 8'hAA;

    pulse_init();
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp", {29'd0, resp_valid, resp_err, mem_MemW}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_maddr", mem_address, 32'd0);
    chk("rst_mwdata", {mem_write_data[28:0], mem_funct3}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat, acc);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_acc", i), acc, vecs[i].exp_acc);
    end

    chk("sw_log_n", log_n, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sw_log_addr%0d", i), log_addr[i], 32'h101 + i);
      chk($sformatf("sw_log_data%0d", i), {24'd0, log_data[i]}, {24'd0, exp_b[i]});
      chk($sformatf("sw_log_f3_%0d", i), {29'd0, log_f3[i]}, 32'd0);
    end

    // Reset in the middle of a split store: only the first two bytes land.
    pulse_init();
    @(negedge clk);
    req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h101; req_wdata = 32'hAABBCCDD;
    req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_memw", {31'd0, mem_MemW}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    bad = 0;
    repeat (3) begin @(negedge clk); if (resp_valid) bad++; end
    rst_n = 1'b1;
    repeat (2) begin @(negedge clk); if (resp_valid) bad++; end
    chk("mid_rst_noresp", bad, 32'd0);
    chk("mid_rst_log_n", log_n, 32'd2);
    chk("mid_rst_bytes", {mem[10'h104], mem[10'h103], mem[10'h102], mem[10'h101]},
        32'h5544CCDD);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    run_req(1'b0, 3'b010, 32'h100, 32'h0, rd, er, lat, acc);
    chk("post_rst_rdata", rd, 32'h44CCDD11);
    chk("post_rst_lat", lat, 32'd2);

    // No-split instance: misaligned word is an error, aligned word proceeds.
    @(negedge clk);
    req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h102; nm_valid = 1'b1;
    @(negedge clk); nm_valid = 1'b0;
    chk("nm_mis_resp", {29'd0, nm_resp_valid, nm_err, nm_MemW | nm_memRead}, 32'b110);
    chk("nm_mis_rdata", nm_rdata, 32'd0);
    @(negedge clk);
    req_addr = 32'h100; nm_valid = 1'b1;
    @(negedge clk); nm_valid = 1'b0;
    chk("nm_al_access", {30'd0, nm_memRead, nm_resp_valid}, 32'b10);
    @(negedge clk);
    chk("nm_al_resp", {30'd0, nm_resp_valid, nm_err}, 32'b10);

    chk("never_both_high", both_hi, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/lsu_byte_splitter.md
Name: lsu_byte_splitter

Overview:
- Load/store initiator between the core's memory stage and `data_memory`. It drives that block's existing interface: address, write_data, MemW, memRead, funct3, read_data.
- Aligned accesses pass through as one memory cycle.
- Misaligned halfword/word accesses are split into sequential byte accesses (sb/lbu), then reassembled with correct sign/zero extension.
- The core side uses a valid/ready request and a one-cycle response pulse.

Parameters:
- ALLOW_MISALIGNED, 1, 1 = split misaligned accesses into bytes; 0 = answer them with resp_err and make no memory access.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  core request present.
- req_ready  output  1  high only in IDLE; a request is accepted on a rising edge where req_valid && req_ready.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I load/store funct3.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the low bytes are used according to size.
- resp_valid  output  1  one-cycle pulse; response complete.
- resp_rdata  output  32  load result, valid with resp_valid; 0 for stores and errors.
- resp_err  output  1  valid with resp_valid; illegal funct3, or misaligned access with ALLOW_MISALIGNED=0.
- mem_address  output  32  to data_memory address.
- mem_write_data  output  32  to data_memory write_data.
- mem_MemW  output  1  to data_memory MemW.
- mem_memRead  output  1  to data_memory memRead.
- mem_funct3  output  3  to data_memory funct3.
- mem_read_data  input  32  from data_memory read_data; combinational read.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; req_ready = 1.
  - resp_valid, resp_err, resp_rdata = 0; mem_MemW, mem_memRead = 0; mem_address, mem_write_data, mem_funct3 = 0.
  - Reset mid-operation abandons the request. Bytes already written stay written. No response is produced.
- Request capture: on acceptance, register write, funct3, addr, wdata, byte count N and a misaligned flag.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else is an error.
- Misaligned:
  - h/hu with addr[0] = 1: N = 2.
  - w with addr[1:0] != 0: N = 4.
  - Otherwise N = 1 (aligned).
- States: IDLE, ACCESS, RESP.
  - IDLE -> ACCESS on accept of a legal request.
  - IDLE -> RESP on accept of an error request. resp_err = 1, rdata = 0, and there is no memory access.
  - ACCESS loops while byte counter k < N-1 (k increments each cycle). ACCESS -> RESP when k = N-1.
  - RESP -> IDLE unconditionally. resp_valid is high for exactly one cycle.
- ACCESS, aligned:
  - mem_address = addr, mem_funct3 = funct3, mem_write_data = wdata.
  - Store: mem_MemW = 1; write commits at the edge ending the cycle.
  - Load: mem_memRead = 1; resp_rdata <= mem_read_data at the edge ending the cycle.
- ACCESS, split (byte k, 0..N-1):
  - mem_address = addr + k, 32-bit wrap.
  - Store: mem_funct3 = 000, mem_write_data = {24'b0, wdata[8k+7:8k]}, mem_MemW = 1.
  - Load: mem_funct3 = 100, mem_memRead = 1; mem_read_data[7:0] is captured into byte lane k of an assembly register.
  - Final load result:
    - lh: sign-extend bit 15.
    - lhu: zero-extend.
    - lw: 32-bit assembled value as is.
- mem_MemW and mem_memRead are 0 in every state other than ACCESS. They are never both 1.
- Latency, accept edge at end of cycle T:
  - ACCESS occupies T+1 .. T+N.
  - resp_valid in cycle T+N+1.
  - req_ready again in T+N+2.
  - Error request: resp_valid in T+1.
- Requests presented while req_ready = 0 are ignored and not queued. req_* may change freely after acceptance.
- resp_rdata holds its value until the next response. resp_err is 0 on non-error responses.

Test Plan:
- Preload word 0x100 = 0x44332211, word 0x104 = 0x88776655. lw 0x100 accepted at T -> one ACCESS with mem_funct3 = 010; resp_valid at T+2, rdata 0x44332211, resp_err 0.
- lw 0x102 -> four lbu accesses to addresses 0x102..0x105; resp_valid at T+5, rdata 0x66554433.
- lh 0x107 on word 0x104 = 0x88776655 with word 0x108 = 0x000000F0:
  - Expect two accesses (0x107, 0x108) and rdata 0xFFFFF088.
  - lhu at the same address -> 0x0000F088.
  - lb 0x107 -> single access, 0xFFFFFF88.
- sw 0x101 with wdata 0xAABBCCDD:
  - Bytes written in order DD@0x101, CC@0x102, BB@0x103, AA@0x104.
  - Then word 0x100 = 0xBBCCDD11, word 0x104 = 0x887766AA; resp_rdata 0.
- Illegal requests:
  - req_funct3 = 011 load -> resp_valid at T+1, resp_err 1, rdata 0, mem_MemW and mem_memRead never high.
  - With ALLOW_MISALIGNED = 0, lw 0x102 -> same error response.
- Reset mid split: during sw 0x101, drop rst_n after the second byte cycle.
  - mem_MemW falls immediately; only 0x101 and 0x102 are modified; no resp_valid.
  - req_ready = 1 after release; a new aligned lw completes normally.
